// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the execute-side branch resolution unit:
// FSM state encoding, the prediction bundle layout and counter limits.
package branch_resolve_unit_pkg;

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_RECOVER = 1'b1;

  localparam int unsigned BRU_WIDTH = 32;
  localparam int unsigned BRU_CNT_W = 16;

  localparam logic [BRU_CNT_W-1:0] BRU_CNT_MAX = {BRU_CNT_W{1'b1}};

  // Prediction travelling with an instruction at the default PC width.
  typedef struct packed {
    logic                 valid;
    logic                 pred;
    logic [BRU_WIDTH-1:0] target;
    logic [BRU_WIDTH-1:0] pc4;
  } pred_bundle_t;

endpackage

// File: rtl/branch_resolve_unit_pipe.sv
// Prediction-bundle pipeline register with load enable and a synchronous
// clear that takes priority over the enable.
module branch_pipe_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         i_reset_n,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic         i_valid,
  input  logic         i_pred,
  input  logic [W-1:0] i_target,
  input  logic [W-1:0] i_pc4,
  output logic         o_valid,
  output logic         o_pred,
  output logic [W-1:0] o_target,
  output logic [W-1:0] o_pc4
);

  logic         r_valid;
  logic         r_pred;
  logic [W-1:0] r_target;
  logic [W-1:0] r_pc4;

  // Bundle storage: reset and clear both produce an empty (invalid) slot.
  always_ff @(posedge clk) begin
    if (!i_reset_n || i_clr) begin
      r_valid  <= 1'b0;
      r_pred   <= 1'b0;
      r_target <= {W{1'b0}};
      r_pc4    <= {W{1'b0}};
    end else if (i_en) begin
      r_valid  <= i_valid;
      r_pred   <= i_pred;
      r_target <= i_target;
      r_pc4    <= i_pc4;
    end else begin
      r_valid  <= r_valid;
      r_pred   <= r_pred;
      r_target <= r_target;
      r_pc4    <= r_pc4;
    end
  end

  assign o_valid  = r_valid;
  assign o_pred   = r_pred;
  assign o_target = r_target;
  assign o_pc4    = r_pc4;

endmodule

// File: rtl/branch_resolve_unit.sv
// Carries fetch-time predictions to Execute, detects mispredictions there,
// raises redirect/flush, and keeps saturating branch statistics.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PredictTakenF,
  input  logic [WIDTH-1:0] PredTargetF,
  input  logic [WIDTH-1:0] PCPlus4F,
  input  logic             StallD,
  input  logic             FlushE_hz,
  input  logic             BranchE,
  input  logic             BranchTakenE,
  input  logic [WIDTH-1:0] BranchTargetE,
  output logic             MispredictE,
  output logic [WIDTH-1:0] RedirectPCE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             Recovering,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] MispredCount
);

  logic             w_vD, w_predD, w_vE, w_predE;
  logic [WIDTH-1:0] w_tgtD, w_pc4D, w_tgtE, w_pc4E;
  logic             w_chk, w_mispred;
  logic [0:0]       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_branch_cnt, r_mispred_cnt;
  logic [WIDTH-1:0] w_redirect;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_TOP = {CNT_W{1'b1}};

  branch_pipe_reg #(.W(WIDTH)) u_reg_d (
    .clk       (clk),
    .i_reset_n (reset),
    .i_en      (~StallD),
    .i_clr     (FlushD),
    .i_valid   (1'b1),
    .i_pred    (PredictTakenF),
    .i_target  (PredTargetF),
    .i_pc4     (PCPlus4F),
    .o_valid   (w_vD),
    .o_pred    (w_predD),
    .o_target  (w_tgtD),
    .o_pc4     (w_pc4D)
  );

  branch_pipe_reg #(.W(WIDTH)) u_reg_e (
    .clk       (clk),
    .i_reset_n (reset),
    .i_en      (1'b1),
    .i_clr     (FlushE),
    .i_valid   (w_vD),
    .i_pred    (w_predD),
    .i_target  (w_tgtD),
    .i_pc4     (w_pc4D),
    .o_valid   (w_vE),
    .o_pred    (w_predE),
    .o_target  (w_tgtE),
    .o_pc4     (w_pc4E)
  );

  // A taken prediction to the wrong target is as bad as a wrong direction.
  assign w_chk     = w_vE & BranchE & (r_state == ST_RUN);
  assign w_mispred = w_chk & ((w_predE != BranchTakenE) |
                              (w_predE & BranchTakenE & (w_tgtE != BranchTargetE)));

  // Correct next-fetch PC selection.
  always_comb begin
    w_redirect = {WIDTH{1'b0}};
    if (w_mispred) begin
      if (BranchTakenE) begin
        w_redirect = BranchTargetE;
      end else begin
        w_redirect = w_pc4E;
      end
    end else begin
      w_redirect = {WIDTH{1'b0}};
    end
  end

  // Recovery FSM next state.
  always_comb begin
    w_state_nxt = ST_RUN;
    case (r_state)
      ST_RUN:     w_state_nxt = w_mispred ? ST_RECOVER : ST_RUN;
      ST_RECOVER: w_state_nxt = ST_RUN;
      default:    w_state_nxt = ST_RUN;
    endcase
  end

  // State register and saturating statistics counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= ST_RUN;
      r_branch_cnt  <= {CNT_W{1'b0}};
      r_mispred_cnt <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if (w_chk && (r_branch_cnt != CNT_TOP)) begin
        r_branch_cnt <= r_branch_cnt + CNT_ONE;
      end else begin
        r_branch_cnt <= r_branch_cnt;
      end
      if (w_mispred && (r_mispred_cnt != CNT_TOP)) begin
        r_mispred_cnt <= r_mispred_cnt + CNT_ONE;
      end else begin
        r_mispred_cnt <= r_mispred_cnt;
      end
    end
  end

  assign MispredictE  = w_mispred;
  assign RedirectPCE  = w_redirect;
  assign FlushD       = w_mispred;
  assign FlushE       = w_mispred | FlushE_hz;
  assign Recovering   = (r_state == ST_RECOVER);
  assign BranchCount  = r_branch_cnt;
  assign MispredCount = r_mispred_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed scenarios followed by
// random traffic, checked against a cycle-level behavioural model.
module tb_branch_resolve_unit;

  localparam int W    = 32;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          PredictTakenF, StallD, FlushE_hz, BranchE, BranchTakenE;
  logic [W-1:0]  PredTargetF, PCPlus4F, BranchTargetE;
  logic          MispredictE, FlushD, FlushE, Recovering;
  logic [W-1:0]  RedirectPCE;
  logic [CW-1:0] BranchCount, MispredCount;

  branch_resolve_unit #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .PredictTakenF (PredictTakenF),
    .PredTargetF   (PredTargetF),
    .PCPlus4F      (PCPlus4F),
    .StallD        (StallD),
    .FlushE_hz     (FlushE_hz),
    .BranchE       (BranchE),
    .BranchTakenE  (BranchTakenE),
    .BranchTargetE (BranchTargetE),
    .MispredictE   (MispredictE),
    .RedirectPCE   (RedirectPCE),
    .FlushD        (FlushD),
    .FlushE        (FlushE),
    .Recovering    (Recovering),
    .BranchCount   (BranchCount),
    .MispredCount  (MispredCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         valid;
    bit         pred;
    logic [W-1:0] tgt;
    logic [W-1:0] pc4;
  } slot_t;

  typedef struct {
    bit           mis;
    logic [W-1:0] rpc;
    bit           fd;
    bit           fe;
    bit           rec;
    int           bc;
    int           mc;
  } exp_t;

  exp_t  exp_q[$];
  slot_t m_d, m_e;
  slot_t empty_slot;
  bit    m_recovering;
  int    m_bc, m_mc;
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // One clock of stimulus: drive, predict the visible outputs, advance the model.
  task automatic cycle(input bit rst_n, input bit ptf, input logic [W-1:0] ptg,
                       input logic [W-1:0] pc4, input bit st, input bit fhz,
                       input bit br, input bit tk, input logic [W-1:0] btg);
    exp_t  e;
    bit    resolving;
    slot_t fetched;
    @(posedge clk);
    #1;
    reset = rst_n; PredictTakenF = ptf; PredTargetF = ptg; PCPlus4F = pc4;
    StallD = st; FlushE_hz = fhz; BranchE = br; BranchTakenE = tk; BranchTargetE = btg;

    resolving = m_e.valid && br && !m_recovering;
    e.mis = resolving && ((m_e.pred != tk) || (tk && m_e.tgt != btg));
    if (e.mis) e.rpc = tk ? btg : m_e.pc4;
    else       e.rpc = '0;
    e.fd  = e.mis;
    e.fe  = e.mis || fhz;
    e.rec = m_recovering;
    e.bc  = m_bc;
    e.mc  = m_mc;
    exp_q.push_back(e);

    if (!rst_n) begin
      m_d = empty_slot; m_e = empty_slot;
      m_recovering = 1'b0; m_bc = 0; m_mc = 0;
    end else begin
      fetched = '{valid: 1'b1, pred: ptf, tgt: ptg, pc4: pc4};
      m_e = e.fe ? empty_slot : m_d;
      if (e.fd)      m_d = empty_slot;
      else if (!st)  m_d = fetched;
      m_recovering = e.mis;
      if (resolving && m_bc < CMAX) m_bc++;
      if (e.mis && m_mc < CMAX)     m_mc++;
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare it.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("MispredictE",  64'(MispredictE),  64'(e.mis));
      check("RedirectPCE",  64'(RedirectPCE),  64'(e.rpc));
      check("FlushD",       64'(FlushD),       64'(e.fd));
      check("FlushE",       64'(FlushE),       64'(e.fe));
      check("Recovering",   64'(Recovering),   64'(e.rec));
      check("BranchCount",  64'(BranchCount),  64'(e.bc));
      check("MispredCount", 64'(MispredCount), 64'(e.mc));
    end
  end

  initial begin
    logic [W-1:0] pool [4];
    empty_slot = '{valid: 1'b0, pred: 1'b0, tgt: '0, pc4: '0};
    m_d = empty_slot; m_e = empty_slot;
    m_recovering = 1'b0; m_bc = 0; m_mc = 0;
    pool[0] = 32'h100; pool[1] = 32'h200; pool[2] = 32'h300; pool[3] = 32'h400;

    reset = 1'b0; PredictTakenF = 1'b0; PredTargetF = '0; PCPlus4F = '0;
    StallD = 1'b0; FlushE_hz = 1'b0; BranchE = 1'b0; BranchTakenE = 1'b0; BranchTargetE = '0;
    repeat (2) @(posedge clk);

    // Correctly predicted not-taken branch
    cycle(1, 0, 32'h0,   32'h104, 0, 0, 0, 0, 32'h0);
    cycle(1, 0, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0);
    cycle(1, 0, 32'h0,   32'h0,   0, 0, 1, 0, 32'h0);
    // Taken, predicted not-taken
    cycle(1, 0, 32'h0,   32'h204, 0, 0, 0, 0, 32'h0);
    cycle(1, 0, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0);
    cycle(1, 0, 32'h0,   32'h0,   0, 0, 1, 1, 32'h300);
    cycle(1, 0, 32'h0,   32'h0,   0, 0, 1, 1, 32'h300);
    // Not-taken, predicted taken
    cycle(1, 1, 32'h400, 32'h108, 0, 0, 0, 0, 32'h0);
    cycle(1, 0, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0);
    cycle(1, 0, 32'h0,   32'h0,   0, 0, 1, 0, 32'h0);
    cycle(1, 0, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0);
    // Direction right, target wrong
    cycle(1, 1, 32'h500, 32'h504, 0, 0, 0, 0, 32'h0);
    cycle(1, 0, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0);
    cycle(1, 0, 32'h0,   32'h0,   0, 0, 1, 1, 32'h540);
    cycle(1, 0, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0);
    // Stall holds D; a mispredict during stall clears it
    cycle(1, 1, 32'h600, 32'h604, 0, 0, 0, 0, 32'h0);
    cycle(1, 0, 32'h700, 32'h704, 1, 0, 0, 0, 32'h0);
    cycle(1, 0, 32'h710, 32'h714, 1, 0, 1, 1, 32'h600);
    cycle(1, 0, 32'h720, 32'h724, 1, 0, 1, 0, 32'h0);
    cycle(1, 0, 32'h730, 32'h734, 1, 1, 1, 0, 32'h0);
    cycle(1, 0, 32'h0,   32'h0,   0, 0, 1, 0, 32'h0);
    // Reset in the middle of recovery
    cycle(1, 0, 32'h0,   32'h804, 0, 0, 0, 0, 32'h0);
    cycle(1, 0, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0);
    cycle(1, 0, 32'h0,   32'h0,   0, 0, 1, 1, 32'h900);
    cycle(0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0);
    cycle(1, 0, 32'h0,   32'h0,   0, 0, 1, 1, 32'h900);

    // Random traffic: small target pool so predictions often match
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(199) != 0),
            1'($urandom_range(1)),
            pool[$urandom_range(3)],
            32'($urandom) & 32'hFFFF_FFFC,
            ($urandom_range(3) == 0),
            ($urandom_range(7) == 0),
            1'($urandom_range(1)),
            1'($urandom_range(1)),
            pool[$urandom_range(3)]);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-side counterpart of the 2-bit branch predictor: carries each fetch-time prediction (taken bit, predicted target, fall-through PC) down the F→D→E pipeline alongside its instruction.
- When a branch resolves in Execute, compares the actual outcome with the prediction, and on mismatch raises a redirect with the correct PC plus Decode/Execute flushes.
- Keeps saturating branch and mispredict counters for performance reporting.

Parameters:
- WIDTH, 32, PC/target width in bits.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset: reset==0 at a rising edge of clk resets the block.
- PredictTakenF  in  1  predictor output for the instruction in Fetch.
- PredTargetF  in  WIDTH  predicted target for the Fetch instruction.
- PCPlus4F  in  WIDTH  fall-through PC of the Fetch instruction.
- StallD  in  1  hold the F→D stage.
- FlushE_hz  in  1  hazard-unit bubble into Execute.
- BranchE  in  1  instruction in Execute is a branch.
- BranchTakenE  in  1  actual branch outcome (condition passed).
- BranchTargetE  in  WIDTH  actual branch target.
- MispredictE  out  1  misprediction detected this cycle.
- RedirectPCE  out  WIDTH  correct next-fetch PC when MispredictE=1, else 0.
- FlushD  out  1  squash the Decode stage.
- FlushE  out  1  squash the Execute stage (includes FlushE_hz).
- Recovering  out  1  high for the one cycle after a mispredict.
- BranchCount  out  CNT_W  resolved branches, saturating.
- MispredCount  out  CNT_W  mispredicts, saturating.

Behaviour:
- Reset (reset==0 at posedge): all pipe registers cleared, valid bits 0, state RUN, both counters 0. Combinational outputs read 0 as a result.
- D register {vD, predD, tgtD, pc4D}:
  - loads {1, PredictTakenF, PredTargetF, PCPlus4F} when StallD=0;
  - holds when StallD=1;
  - clears when FlushD=1, which overrides StallD.
- E register {vE, predE, tgtE, pc4E}:
  - loads the D register contents every cycle;
  - clears when FlushE=1.
- Resolution (combinational, same cycle as BranchE): chk = vE & BranchE & (state==RUN). Mispredict = chk & ((predE != BranchTakenE) | (predE & BranchTakenE & (tgtE != BranchTargetE))).
- RedirectPCE:
  - BranchTargetE if Mispredict=1 and BranchTakenE=1;
  - pc4E if Mispredict=1 and BranchTakenE=0;
  - 0 otherwise.
- Flushes: FlushD = MispredictE. FlushE = MispredictE | FlushE_hz.
- FSM, two states:
  - RUN→RECOVER on MispredictE.
  - RECOVER→RUN unconditionally after 1 cycle. Recovering = (state==RECOVER).
  - In RECOVER, resolution is masked. E holds a flushed bubble, so the mask is a safety net only.
- Counters:
  - BranchCount increments when chk=1; MispredCount increments when MispredictE=1.
  - Each saturates at 2^CNT_W-1 and does not wrap.
- Simultaneous events:
  - Mispredict and StallD together: the flush wins and D clears.
  - FlushE_hz during a mispredict: identical result.
  - BranchE with vE=0: ignored, no count.
- Latency: mispredict detection is 0-cycle, combinational from the E inputs. Corrected fetch begins the following cycle.
- reset==0 mid-recovery returns the block to RUN with cleared registers and counters.

Decomposition:
- Shared package: state encoding (RUN=1'b0, RECOVER=1'b1), prediction-bundle typedef {valid, pred, target, pc4}, and a counter-max constant.
- One natural sub-module: branch_pipe_reg, a parameterized bundle register with enable and synchronous clear. It is instantiated twice, for D and E.

Test Plan:
- Reset: hold reset=0 for 2 cycles, release → MispredictE=0, both counters=0, Recovering=0.
- Correct not-taken: PredictTakenF=0, PCPlus4F=0x104. Two cycles later BranchE=1, BranchTakenE=0 → MispredictE=0, BranchCount=1.
- Taken but predicted not-taken: PredictTakenF=0, PCPlus4F=0x204. In E, BranchTakenE=1, BranchTargetE=0x300 → MispredictE=1, RedirectPCE=0x300, FlushD=FlushE=1. Next cycle Recovering=1. MispredCount=1.
- Not-taken but predicted taken: PredictTakenF=1, PredTargetF=0x400, PCPlus4F=0x108. BranchTakenE=0 → RedirectPCE=0x108.
- Target mismatch: pred=1, PredTargetF=0x500, actual taken to 0x540 → MispredictE=1, RedirectPCE=0x540.
- Stall/flush interplay and saturation:
  - StallD=1 for 3 cycles → the D bundle is held.
  - A mispredict during StallD=1 → D clears.
  - With CNT_W=2, 5 mispredicts → MispredCount=3.
